serial_magnitude_compare_ctrl: RTL

- Sequencer that compares two WIDTH-bit unsigned words, two bits per cycle, starting at the MSB.
- Drives a 2-bit greater/equal/less slice comparator. The slice logic is instantiated inline with the same f1/f2/f3 equations.
- Terminates early on the first unequal slice.
- Sits between a requester and the comparator datapath, using a start/done handshake.

---
 rtl/serial_magnitude_compare_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/serial_magnitude_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_magnitude_compare_ctrl
// Description : Sequencer that compares two WIDTH-bit unsigned words two bits
//               per cycle, MSB slice first, using an inline 2-bit
//               greater/equal/less slice comparator. Stops on the first
//               unequal slice. Start/done handshake toward the requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset
//   start   in   1        request, sampled only in IDLE or DONE
//   a, b    in   WIDTH    operands, latched on an accepted start
//   busy    out  1        high while comparing
//   done    out  1        one-cycle pulse when the result becomes valid
//   gt/eq/lt out 1        A > B / A == B / A < B (one-hot once done)
//   slices  out  clog2(WIDTH/2)+1  slices examined for current/last operation
// ============================================================================
module serial_magnitude_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       gt,
    output logic                       eq,
    output logic                       lt,
    output logic [$clog2(WIDTH/2):0]   slices
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SW     = $clog2(NSLICE) + 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("serial_magnitude_compare_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [SW-1:0]    slices_q, slices_d;

    // Select the slice currently addressed by idx_q.
    logic [1:0] sa, sb;
    always_comb begin
        sa = 2'b00;
        sb = 2'b00;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                sa = a_q[2*i +: 2];
                sb = b_q[2*i +: 2];
            end
        end
    end

    // 2-bit slice comparator (f1 = greater, f2 = equal, f3 = less).
    logic s_gt, s_eq, s_lt, hi_eq;
    always_comb begin
        hi_eq = ~(sa[1] ^ sb[1]);
        s_gt  = (sa[1] & ~sb[1]) | (hi_eq & sa[0] & ~sb[0]);
        s_eq  = hi_eq & ~(sa[0] ^ sb[0]);
        s_lt  = (~sa[1] & sb[1]) | (hi_eq & ~sa[0] & sb[0]);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        slices_d = slices_q;
        case (state_q)
            S_COMPARE: begin
                slices_d = slices_q + 1'b1;
                if (s_gt) begin
                    gt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (s_lt) begin
                    lt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    // Last slice equal: finish before idx could wrap.
                    eq_d    = s_eq;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a start (DONE gives back-to-back).
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = IDX_TOP;
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    slices_d = '0;
                    state_d  = S_COMPARE;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d == S_COMPARE);
        done_d = (state_q == S_COMPARE) && (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            slices_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            slices_q <= slices_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign eq     = eq_q;
    assign lt     = lt_q;
    assign slices = slices_q;

endmodule
`default_nettype wire
